// File: rtl/my_mod_pkg.sv
// Shared types for the my_mod accumulate/shift/logic unit: operand width,
// opcode enum and the result bundle carried down the output pipeline.
package my_mod_pkg;

   localparam int unsigned WIDTH = 9;

   typedef enum logic [2:0] {
      OP_LOAD = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_SHL  = 3'd3,
      OP_SHR  = 3'd4,
      OP_SRA  = 3'd5,
      OP_XOR  = 3'd6,
      OP_XNOR = 3'd7
   } op_e;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             carry;
      logic             zero;
      logic             parity;
   } result_t;

   // Idle/reset contents of a stage: zero data, so the zero flag reads 1.
   localparam result_t RESULT_IDLE = '{data: '0, carry: 1'b0, zero: 1'b1, parity: 1'b0};

   function automatic result_t mk_result(input logic [WIDTH-1:0] data, input logic carry);
      result_t res;
      res.data   = data;
      res.carry  = carry;
      res.zero   = ~|data;
      res.parity = ^data;
      return res;
   endfunction

endpackage

// File: rtl/my_mod_pipe.sv
// Output pipeline: DEPTH stages of result_t plus valid, all advancing together
// on a common enable so a stalled output freezes every stage.
module my_mod_pipe
   import my_mod_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    i_en,
   input  logic    i_valid,
   input  result_t i_data,
   output logic    o_valid,
   output result_t o_data
);

   logic    r_valid [DEPTH];
   result_t r_data  [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_valid[i] <= 1'b0;
            r_data[i]  <= RESULT_IDLE;
         end
      end else if (i_en) begin
         r_valid[0] <= i_valid;
         r_data[0]  <= i_data;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/my_mod.sv
// 9-bit accumulate/shift/logic unit: accumulator + ALU with valid/ready input,
// results delivered through a Y-stage backpressured output pipeline.
module my_mod
   import my_mod_pkg::*;
#(
   parameter int unsigned X = 1,
   parameter int unsigned Y = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] foo,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] x,
   output logic             carry,
   output logic             zero,
   output logic             parity
);

   logic [WIDTH-1:0] r_acc;
   logic             w_stall;
   logic             w_accept;
   logic [WIDTH:0]   w_wide;
   logic [WIDTH-1:0] w_data;
   logic             w_carry;
   result_t          w_res;
   result_t          w_pipe_in;
   result_t          w_pipe_out;

   assign w_stall  = out_valid & ~out_ready;
   assign in_ready = ~w_stall;
   assign w_accept = in_valid & in_ready;

   always_comb begin
      w_wide  = '0;
      w_data  = '0;
      w_carry = 1'b0;
      case (op_e'(op))
         OP_LOAD: w_data = foo;
         OP_ADD: begin
            w_wide  = {1'b0, r_acc} + {1'b0, foo};
            w_data  = w_wide[WIDTH-1:0];
            w_carry = w_wide[WIDTH];
         end
         OP_SUB: begin
            // Bit WIDTH of the widened difference is the borrow.
            w_wide  = {1'b0, r_acc} - {1'b0, foo};
            w_data  = w_wide[WIDTH-1:0];
            w_carry = w_wide[WIDTH];
         end
         OP_SHL:  w_data = r_acc << X;
         OP_SHR:  w_data = r_acc >> X;
         OP_SRA:  w_data = $signed(r_acc) >>> X;
         OP_XOR:  w_data = r_acc ^ foo;
         OP_XNOR: w_data = ~(r_acc ^ foo);
         default: w_data = '0;
      endcase
      w_res = mk_result(w_data, w_carry);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_accept) begin
         r_acc <= w_res.data;
      end
   end

   assign w_pipe_in = w_accept ? w_res : RESULT_IDLE;

   my_mod_pipe #(
      .DEPTH(Y)
   ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_en    (~w_stall),
      .i_valid (w_accept),
      .i_data  (w_pipe_in),
      .o_valid (out_valid),
      .o_data  (w_pipe_out)
   );

   assign x      = w_pipe_out.data;
   assign carry  = w_pipe_out.carry;
   assign zero   = w_pipe_out.zero;
   assign parity = w_pipe_out.parity;

endmodule

// File: tb/tb_my_mod.sv
// Directed self-checking bench for my_mod with default X=1, Y=2.
module tb_my_mod;

   localparam int unsigned TB_X = 1;
   localparam int unsigned TB_Y = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [8:0] foo;
   logic       out_ready;
   logic       out_valid;
   logic [8:0] x;
   logic       carry;
   logic       zero;
   logic       parity;

   // {out_valid, x, carry, zero, parity}
   logic [12:0] obs;
   assign obs = {out_valid, x, carry, zero, parity};

   int n_cmp = 0;
   int n_err = 0;

   my_mod #(
      .X(TB_X),
      .Y(TB_Y)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .foo       (foo),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .x         (x),
      .carry     (carry),
      .zero      (zero),
      .parity    (parity)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Issue one op and return in the cycle its result is on the outputs.
   task automatic run_op(input logic [2:0] o, input logic [8:0] f);
      in_valid = 1'b1;
      op = o;
      foo = f;
      step();
      in_valid = 1'b0;
      repeat (TB_Y - 1) step();
   endtask

   task automatic test_reset();
      n_cmp++;
      if (obs !== {1'b0, 9'h000, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL reset_outputs: got %h want %h", obs, {1'b0, 9'h000, 1'b0, 1'b1, 1'b0});
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      in_valid = 1'b1; op = 3'd0; foo = 9'd5;
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs !== {1'b0, 9'h000, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL midreset_outputs: got %h want %h", obs, {1'b0, 9'h000, 1'b0, 1'b1, 1'b0});
      end
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (out_valid !== 1'b0 || x === 9'd5) begin
            n_err++; $display("FAIL midreset_no_result cyc%0d: got valid=%b x=%h want valid=0", i, out_valid, x);
         end
         step();
      end
      run_op(3'd1, 9'd0);
      n_cmp++;
      if (obs !== {1'b1, 9'h000, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL midreset_acc_cleared: got %h want %h", obs, {1'b1, 9'h000, 1'b0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      in_valid = 1'b1; op = 3'd0; foo = 9'd5;
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_latency: got valid=%b want 0", out_valid);
      end
      op = 3'd1; foo = 9'd3;
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (obs !== {1'b1, 9'h005, 1'b0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL b2b_load5: got %h want %h", obs, {1'b1, 9'h005, 1'b0, 1'b0, 1'b0});
      end
      step();
      n_cmp++;
      if (obs !== {1'b1, 9'h008, 1'b0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL b2b_add3: got %h want %h", obs, {1'b1, 9'h008, 1'b0, 1'b0, 1'b1});
      end
      step();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL b2b_drain: got valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_sub_wrap();
      do_reset();
      run_op(3'd2, 9'd1);
      n_cmp++;
      if (obs !== {1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL sub_borrow: got %h want %h", obs, {1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1});
      end
      run_op(3'd1, 9'd1);
      n_cmp++;
      if (obs !== {1'b1, 9'h000, 1'b1, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL add_wrap: got %h want %h", obs, {1'b1, 9'h000, 1'b1, 1'b1, 1'b0});
      end
   endtask

   task automatic test_shifts();
      do_reset();
      run_op(3'd0, 9'h100);
      run_op(3'd5, 9'h000);
      n_cmp++;
      if (obs !== {1'b1, 9'h180, 1'b0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL sra: got %h want %h", obs, {1'b1, 9'h180, 1'b0, 1'b0, 1'b0});
      end
      run_op(3'd0, 9'h100);
      run_op(3'd4, 9'h000);
      n_cmp++;
      if (obs !== {1'b1, 9'h080, 1'b0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL shr: got %h want %h", obs, {1'b1, 9'h080, 1'b0, 1'b0, 1'b1});
      end
      run_op(3'd0, 9'h100);
      run_op(3'd3, 9'h000);
      n_cmp++;
      if (obs !== {1'b1, 9'h000, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL shl: got %h want %h", obs, {1'b1, 9'h000, 1'b0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_logic();
      do_reset();
      run_op(3'd0, 9'h0FF);
      run_op(3'd7, 9'h0F0);
      n_cmp++;
      if (obs !== {1'b1, 9'h1F0, 1'b0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL xnor: got %h want %h", obs, {1'b1, 9'h1F0, 1'b0, 1'b0, 1'b1});
      end
      run_op(3'd6, 9'h1F0);
      n_cmp++;
      if (obs !== {1'b1, 9'h000, 1'b0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL xor: got %h want %h", obs, {1'b1, 9'h000, 1'b0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_backpressure();
      logic [8:0] exp_x [3];
      do_reset();
      in_valid = 1'b1; op = 3'd0; foo = 9'd1;
      step();
      foo = 9'd2;
      step();
      // LOAD 2 accepted, result 1 now valid; stall it with LOAD 3 pending.
      foo = 9'd3;
      out_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (in_ready !== 1'b0 || obs !== {1'b1, 9'h001, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL bp_stall cyc%0d: got in_ready=%b out=%h want in_ready=0 out=%h",
                              i, in_ready, obs, {1'b1, 9'h001, 1'b0, 1'b0, 1'b1});
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1 || obs !== {1'b1, 9'h001, 1'b0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL bp_release: got in_ready=%b out=%h want in_ready=1 out=%h",
                           in_ready, obs, {1'b1, 9'h001, 1'b0, 1'b0, 1'b1});
      end
      step();
      foo = 9'd4;
      exp_x[0] = 9'd2; exp_x[1] = 9'd3; exp_x[2] = 9'd4;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || x !== exp_x[i]) begin
            n_err++; $display("FAIL bp_order idx%0d: got valid=%b x=%h want valid=1 x=%h", i, out_valid, x, exp_x[i]);
         end
         if (i == 0) begin
            step();
            in_valid = 1'b0;
         end else begin
            step();
         end
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_no_dup: got valid=%b x=%h want valid=0", out_valid, x);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      op = 3'd0;
      foo = 9'd0;
      out_ready = 1'b1;
      step();
      step();
      test_reset();
      rst = 1'b0;
      test_reset_midstream();
      test_back_to_back();
      test_sub_wrap();
      test_shifts();
      test_logic();
      test_backpressure();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/my_mod.md
# my_mod

Parameterised 9-bit accumulate/shift/logic unit with a valid/ready input, a backpressured output and a configurable output pipeline. Each accepted operation combines the internal accumulator with the input operand and writes the result back to the accumulator. The result, with status flags, emerges `Y` stages later. It is instantiated as a leaf datapath block beside `mod1` controllers, and takes 9-bit buses on its `foo`/`x` ports.

## Interface
- `X`, default 1: shift distance for SHL/SHR/SRA, legal range 0..8.
- `Y`, default 2: output pipeline depth in stages, legal range 1..8.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: unit can accept an operation.
- `op` in 3: operation code (see Operation).
- `foo` in 9: operand.
- `out_ready` in 1: consumer accepts the result.
- `out_valid` out 1: `x` and flags are valid.
- `x` out 9: result.
- `carry` out 1: carry/borrow from ADD/SUB, 0 for all other ops.
- `zero` out 1: `x == 0`.
- `parity` out 1: XOR reduction of `x`.

## Operation
- Accept when `in_valid && in_ready`. `acc` is a 9-bit register; on accept, `acc <= r`.
- Operation codes, with result `r` and `carry`:
  - 0 LOAD: `r = foo`.
  - 1 ADD: `{carry, r} = acc + foo`.
  - 2 SUB: `{carry, r} = {1'b0, acc} - foo`; carry = borrow.
  - 3 SHL: `r = acc << X`.
  - 4 SHR: `r = acc >> X`, logical.
  - 5 SRA: `r = acc >>> X`, with acc treated as signed 9-bit.
  - 6 XOR: `r = acc ^ foo`.
  - 7 XNOR: `r = ~(acc ^ foo)`.
- All arithmetic wraps modulo 512.
- `zero` and `parity` are computed from `r` at the first stage and travel with it.
- Rejected cycles (`in_valid=0` or `in_ready=0`) leave `acc` and `op` sampling unaffected.

## Timing
- Reset values: `acc=0`, all pipeline stages invalid with zero data. Outputs `out_valid=0`, `x=0`, `carry=0`, `zero=1`, `parity=0`, `in_ready=1`.
- Reset asserted mid-operation discards all in-flight results immediately, with no output.
- Latency: an op accepted at edge k appears on the outputs after edge k+Y-1. With the default Y=2, the result is visible in the second cycle after the request cycle.
- Throughput is one op per cycle when not stalled.
- Stall: `stall = out_valid && !out_ready`.
  - While stalled, the whole pipeline holds, `in_ready=0`, and `x`/flags remain stable.
  - No result is dropped or duplicated.
- `in_ready` is a combinational function of `stall` only and does not depend on `in_valid`.
- Simultaneous final-stage handshake and new accept in the same cycle is legal; the pipeline advances by one.
- Back-to-back ops chain through `acc` with no bubble. The second op sees the first op's result.

## Structure
- Shared package `my_mod_pkg` contains:
  - `WIDTH = 9`.
  - Enum `op_e` (LOAD, ADD, SUB, SHL, SHR, SRA, XOR, XNOR = 0..7).
  - Packed struct `result_t` with fields `data`, `carry`, `zero`, `parity`.
- One sub-module, `my_mod_pipe`, carries `result_t` plus a valid bit through `Y` stages with a common stall/enable. The top holds `acc`, the ALU and the handshake logic.

## Test plan
- Reset mid-stream: issue LOAD 5, assert `rst` one cycle later. Outputs return to their reset values at once, and no result 5 ever appears.
- LOAD 5 then ADD 3 back-to-back, with `out_ready=1`. `x=5` then `x=8` on consecutive cycles; the first result appears 2 cycles after the request; `carry=0`.
- From reset, SUB 1. `x=9'h1FF`, `carry=1`, `parity=1`, `zero=0`. Then ADD 1 gives `x=0`, `carry=1`, `zero=1`.
- LOAD `9'h100` then SRA gives `9'h180`. LOAD `9'h100` then SHR gives `9'h080`. LOAD `9'h100` then SHL gives `0` with `zero=1`.
- LOAD `9'h0FF` then XNOR `9'h0F0` gives `9'h1F0`, `parity=1`. Then XOR `9'h1F0` gives `0`.
- Backpressure: stream LOAD 1,2,3,4 while holding `out_ready=0` for 3 cycles once `out_valid` rises.
  - `in_ready=0` and `x` stays stable while stalled.
  - After release, the results 1,2,3,4 appear in order, none lost.
